// File: rtl/merger_pkg.sv
// Shared types and defaults for the merger leaf feeder.
// Holds the coordinate sentinel and the {last, coord} entry layout.
package merger_pkg;

   localparam int DEF_COORD_BITS = 32;
   localparam int DEF_RADIX      = 2;
   localparam int DEF_FIFO_DEPTH = 4;

   // An empty lane presents all-ones so the merger never selects it.
   localparam logic [DEF_COORD_BITS-1:0] COORD_SENTINEL = '1;

   typedef struct packed {
      logic                      last;
      logic [DEF_COORD_BITS-1:0] coord;
   } entry_t;

endpackage

// File: rtl/fiber_lane_fifo.sv
// One leaf lane: FIFO storage, pointers, head mux and fiber status.
// Optional underflow detection under MERGER_FEEDER_UNDERFLOW_EN.
module fiber_lane_fifo
   import merger_pkg::*;
#(
   parameter int W     = DEF_COORD_BITS,
   parameter int DEPTH = DEF_FIFO_DEPTH
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         wr_en,
   input  logic         wr_last,
   input  logic [W-1:0] wr_coord,
   input  logic         pop,
   output logic         full,
   output logic         empty,
   output logic [W-1:0] head,
   output logic         fiber_done,
   output logic         underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   typedef struct packed {
      logic         last;
      logic [W-1:0] coord;
   } lane_entry_t;

   lane_entry_t   mem [DEPTH];
   lane_entry_t   head_e;
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic          wr_ok;
   logic          pop_ok;
   logic          fd_q;

   // Extra pointer bit tells full from empty when indexes coincide.
   assign empty  = (rd_ptr == wr_ptr);
   assign full   = (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]) &&
                   (rd_ptr[PW-1] != wr_ptr[PW-1]);
   assign wr_ok  = wr_en & ~full;
   assign pop_ok = pop & ~empty;
   assign head_e = mem[rd_ptr[AW-1:0]];
   assign head   = empty ? {W{COORD_SENTINEL[0]}} : head_e.coord;

   // Entry storage; contents are only meaningful between the pointers.
   always_ff @(posedge clock) begin
      if (wr_ok) begin
         mem[wr_ptr[AW-1:0]] <= '{last: wr_last, coord: wr_coord};
      end
   end

   // Pointer update; reset discards everything at once.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else begin
         if (wr_ok) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
      end
   end

   // Pulse the cycle after a fiber's final coordinate leaves.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         fd_q <= 1'b0;
      end else begin
         fd_q <= pop_ok & head_e.last;
      end
   end

   assign fiber_done = fd_q;

`ifdef MERGER_FEEDER_UNDERFLOW_EN
   logic uf_q;

   // Sticky flag: merger asked for data the lane did not have.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         uf_q <= 1'b0;
      end else if (pop && empty) begin
         uf_q <= 1'b1;
      end
   end

   assign underflow = uf_q;
`else
   assign underflow = 1'b0;
`endif

endmodule

// File: rtl/merger_feeder.sv
// Leaf feeder: demuxes memory writes into per-lane FIFOs for a merger.
// Build option: MERGER_FEEDER_UNDERFLOW_EN enables sticky underflow flags.
module merger_feeder
   import merger_pkg::*;
#(
   parameter int MERGER_COORD_BITS = DEF_COORD_BITS,
   parameter int MERGER_RADIX      = DEF_RADIX,
   parameter int FIFO_DEPTH        = DEF_FIFO_DEPTH,
   localparam int LW = (MERGER_RADIX > 1) ? $clog2(MERGER_RADIX) : 1,
   localparam int CW = MERGER_RADIX * MERGER_COORD_BITS
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         wr_valid,
   input  logic [LW-1:0]                wr_lane,
   input  logic [MERGER_COORD_BITS-1:0] wr_coord,
   input  logic                         wr_last,
   output logic                         wr_ready,
   output logic [CW-1:0]                coord_out,
   input  logic [MERGER_RADIX-1:0]      fetch_next,
   output logic [MERGER_RADIX-1:0]      lane_empty,
   output logic [MERGER_RADIX-1:0]      fiber_done,
   output logic [MERGER_RADIX-1:0]      underflow
);

   logic [MERGER_RADIX-1:0] lane_full;
   logic [MERGER_RADIX-1:0] lane_wr;
   logic                    sel_ready;

   // Ready comes from the target lane's registered fullness only.
   always_comb begin
      sel_ready = 1'b0;
      for (int i = 0; i < MERGER_RADIX; i++) begin
         if (wr_lane == LW'(i)) begin
            sel_ready = ~lane_full[i];
         end
      end
   end

   assign wr_ready = reset & sel_ready;

   // Route an accepted write to exactly one lane.
   always_comb begin
      lane_wr = '0;
      for (int i = 0; i < MERGER_RADIX; i++) begin
         lane_wr[i] = wr_valid & wr_ready & (wr_lane == LW'(i));
      end
   end

   for (genvar g = 0; g < MERGER_RADIX; g++) begin : g_lane
      fiber_lane_fifo #(
         .W     (MERGER_COORD_BITS),
         .DEPTH (FIFO_DEPTH)
      ) u_lane (
         .clock      (clock),
         .reset      (reset),
         .wr_en      (lane_wr[g]),
         .wr_last    (wr_last),
         .wr_coord   (wr_coord),
         .pop        (fetch_next[g]),
         .full       (lane_full[g]),
         .empty      (lane_empty[g]),
         .head       (coord_out[g*MERGER_COORD_BITS +: MERGER_COORD_BITS]),
         .fiber_done (fiber_done[g]),
         .underflow  (underflow[g])
      );
   end

endmodule
